ex_divider: RTL and testbench
=============================

# ex_divider

Multi-cycle 32-bit integer divider in the EX stage, serving DIV and DIVU after the ID-stage decode has selected the divide ALU operation. It takes rs/rt operand data, runs a radix-2 restoring division for 32 iterations, and holds the pipeline with a stall until the result is ready. On completion it presents the quotient for LO and the remainder for HI; the existing low/high write enables and muxes (alu_res source) commit them.

## Interface
- No parameters; datapath is fixed at 32 bits.
- clk  input  1  pipeline clock; all state updates on rising edge
- resetn  input  1  reset: synchronous, active-low
- div_start  input  1  divide instruction valid in EX (decoded divide select AND EX valid); held high while stalled
- div_signed  input  1  1 = DIV (signed), 0 = DIVU; equals inverted unsigned/op2 control
- src1  input  32  dividend (rs_data, forwarded)
- src2  input  32  divisor (rt_data, forwarded)
- flush  input  1  cancel in-flight divide (exception/ERET)
- div_stall  output  1  freeze PC, IF/ID, ID/EX
- div_done  output  1  one-cycle pulse: quotient/remainder valid
- quotient  output  32  LO write data
- remainder  output  32  HI write data

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE, count=0, quotient=0, remainder=0, div_done=0.
- IDLE: if div_start & ~flush, latch |src1| and |src2| (two's-complement magnitude when div_signed, raw otherwise), record sign_q = src1[31]^src2[31] and sign_r = src1[31] (both forced 0 when unsigned), clear partial remainder, count=0 → CALC.
- CALC: each cycle shift {partial_rem, dividend} left 1; if partial_rem ≥ divisor magnitude, subtract and shift in quotient bit 1, else 0. Compare/subtract is 33-bit unsigned. count increments; after iteration count==31 → DONE.
- DONE: quotient = sign_q ? −q_mag : q_mag; remainder = sign_r ? −r_mag : r_mag (32-bit wrap). Registered outputs update on entry to DONE and are held until the next DONE. div_done=1 for that cycle only → IDLE.
- div_stall = (IDLE & div_start & ~flush) | (CALC & ~flush). Low in DONE, so the pipeline advances on the DONE edge and the HI/LO write is taken that cycle.
- Divide by zero: no trap, deterministic result. Magnitudes give q_mag=0xFFFFFFFF, r_mag=|src1|, then the sign fix is applied. Unsigned: q=0xFFFFFFFF, r=src1. Signed: q=0xFFFFFFFF if src1≥0, else 0x00000001; r=src1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0. No exception.
- flush in any state: → IDLE next edge, count cleared, div_done stays 0, outputs retain previous values. If flush and div_start are both high in IDLE, nothing starts.
- resetn low in any state: IDLE and all outputs zero on that edge, regardless of flush or div_start.
- Operands are sampled only at start; changes on src1/src2 during CALC are ignored.

## Timing
- Start accepted at edge E0, with div_stall high combinationally in the cycle before E0.
- CALC occupies 32 cycles. DONE is the 33rd cycle after acceptance.
- div_stall is high for 33 consecutive cycles (acceptance cycle + 32 CALC), then low in the DONE cycle.
- div_done is high in exactly one cycle, coincident with stable quotient/remainder.
- Back-to-back divides: the next instruction is in EX the cycle after DONE, IDLE accepts it immediately, and no bubble is added by the divider.
- Throughput: one divide per 34 cycles.

## Test plan
- DIVU 100/7: stall 33 cycles, div_done on cycle 33, q=14, r=2; HI/LO written once.
- DIV −7/2 (0xFFFFFFF9/2): q=0xFFFFFFFD, r=0xFFFFFFFF. DIV 7/−2: q=0xFFFFFFFD, r=1.
- Corners: DIV 0x80000000/0xFFFFFFFF → q=0x80000000, r=0. DIVU 5/0 → q=0xFFFFFFFF, r=5. DIV −5/0 → q=1, r=0xFFFFFFFB. DIVU 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
- flush at CALC cycle 10: stall drops the same cycle, no div_done, outputs unchanged. A following DIVU 9/4 → q=2, r=1 with full 33-cycle stall.
- Two consecutive DIVU (20/3 then 20/6): second accepted the cycle after first DONE, results q=6 r=2 then q=3 r=2, no extra stall cycle.
- resetn low at CALC cycle 5 with div_start held: IDLE, outputs 0, div_done never pulses; after release the held div_start restarts and completes normally.

Source files
------------

// File: rtl/ex_divider.sv
// ----------------------------------------------------------------------------
// ex_divider
// Multi-cycle 32-bit integer divider for the EX stage (DIV / DIVU).
// Radix-2 restoring division over 32 iterations. The pipeline is held with
// div_stall until the result is ready. The quotient feeds LO and the
// remainder feeds HI.
//
// Ports
//   clk          pipeline clock, rising edge
//   resetn       synchronous active-low reset
//   div_start    divide instruction valid in EX; held high while stalled
//   div_signed   1 = DIV (signed), 0 = DIVU
//   src1         dividend (rs)
//   src2         divisor  (rt)
//   flush        cancel any in-flight divide
//   div_stall    freeze PC, IF/ID and ID/EX
//   div_done     one-cycle pulse; quotient/remainder valid
//   quotient     LO write data
//   remainder    HI write data
//   dbg_state_o  current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshake: div_start acts as a valid signal. It stays asserted while
// div_stall is high. The divider accepts an operation on the edge ending an
// IDLE cycle that has div_start=1 and flush=0. The result is consumed in the
// single cycle where div_done=1. No stall is asserted in that cycle.
// ----------------------------------------------------------------------------
module ex_divider (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        div_stall,
  output logic        div_done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] dividend_q, dividend_d;   // shifts out dividend, shifts in quotient
  logic [31:0] divisor_q, divisor_d;     // divisor magnitude
  logic [31:0] prem_q, prem_d;           // partial remainder
  logic        sign_q_q, sign_q_d;       // negate quotient at the end
  logic        sign_r_q, sign_r_d;       // negate remainder at the end
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;

  // Operand magnitudes. The magnitude of 0x80000000 wraps to itself, and
  // that is the correct unsigned value.
  logic [31:0] abs1, abs2;
  assign abs1 = (div_signed && src1[31]) ? (32'd0 - src1) : src1;
  assign abs2 = (div_signed && src2[31]) ? (32'd0 - src2) : src2;

  // One restoring step. The 33-bit shifted remainder is compared unsigned.
  // When it is >= divisor, the difference is below the divisor, so 32 bits
  // are enough to hold it.
  logic [32:0] rem_shift;
  logic        ge;
  logic [31:0] prem_sub, prem_next, quot_next, q_final, r_final;

  assign rem_shift = {prem_q, dividend_q[31]};
  assign ge        = (rem_shift >= {1'b0, divisor_q});
  assign prem_sub  = rem_shift[31:0] - divisor_q;
  assign prem_next = ge ? prem_sub : rem_shift[31:0];
  assign quot_next = {dividend_q[30:0], ge};
  assign q_final   = sign_q_q ? (32'd0 - quot_next) : quot_next;
  assign r_final   = sign_r_q ? (32'd0 - prem_next) : prem_next;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    prem_d     = prem_q;
    sign_q_d   = sign_q_q;
    sign_r_d   = sign_r_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    if (flush) begin
      state_d = S_IDLE;
      count_d = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_start) begin
            dividend_d = abs1;
            divisor_d  = abs2;
            sign_q_d   = div_signed & (src1[31] ^ src2[31]);
            sign_r_d   = div_signed & src1[31];
            prem_d     = 32'd0;
            count_d    = 5'd0;
            state_d    = S_CALC;
          end
        end
        S_CALC: begin
          dividend_d = quot_next;
          prem_d     = prem_next;
          count_d    = count_q + 5'd1;
          if (count_q == 5'd31) begin
            // Outputs are registered on entry to DONE, so they are stable
            // while div_done is high.
            quot_d  = q_final;
            rem_d   = r_final;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      count_q    <= 5'd0;
      dividend_q <= 32'd0;
      divisor_q  <= 32'd0;
      prem_q     <= 32'd0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      quot_q     <= 32'd0;
      rem_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      prem_q     <= prem_d;
      sign_q_q   <= sign_q_d;
      sign_r_q   <= sign_r_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
    end
  end

  // The stall is asserted in the accepting cycle so that the divide
  // instruction stays in EX. It drops in DONE so that HI/LO commit on that
  // edge.
  assign div_stall   = ((state_q == S_IDLE) && div_start && !flush) ||
                       ((state_q == S_CALC) && !flush);
  assign div_done    = (state_q == S_DONE) && !flush;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ex_divider.sv
// ----------------------------------------------------------------------------
// tb_ex_divider
// Directed self-checking bench for ex_divider. Each task drives one scenario
// and checks the outputs inline against hand-computed values.
// ----------------------------------------------------------------------------
module tb_ex_divider;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_start;
  logic        div_signed;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        div_stall;
  logic        div_done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [1:0]  dbg_state_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_q  = 32'd0;
  logic [31:0] last_r  = 32'd0;

  // clock / reset
  always #5 clk = ~clk;

  ex_divider dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_start  (div_start),
    .div_signed (div_signed),
    .src1       (src1),
    .src2       (src2),
    .flush      (flush),
    .div_stall  (div_stall),
    .div_done   (div_done),
    .quotient   (quotient),
    .remainder  (remainder),
    .dbg_state_o(dbg_state_o)
  );

  // This task is entered at a falling edge. It asserts a divide and follows
  // it until div_done. It returns at the falling edge of the cycle after
  // DONE, with div_start still high, so the caller can chain another divide
  // or drop div_start. The operands are scrambled during CALC to confirm
  // that they are ignored.
  task automatic run_div(input string name, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
    int          stall_cnt;
    int          done_k;
    logic [31:0] got_q;
    logic [31:0] got_r;
    stall_cnt  = 0;
    done_k     = -1;
    got_q      = 32'hDEAD_BEEF;
    got_r      = 32'hDEAD_BEEF;
    div_start  = 1'b1;
    div_signed = sgn;
    src1       = a;
    src2       = b;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (div_stall) stall_cnt++;
      if (div_done) begin
        done_k = k;
        got_q  = quotient;
        got_r  = remainder;
      end
      if (k == 3) begin
        src1 = ~a;
        src2 = b + 32'd1;
      end
      @(negedge clk);
      if (done_k >= 0) break;
    end
    n_tests++;
    if (stall_cnt !== 33) begin
      n_fail++;
      $display("FAIL %s stall_cycles got %0d exp 33", name, stall_cnt);
    end
    n_tests++;
    if (done_k !== 33) begin
      n_fail++;
      $display("FAIL %s done_cycle got %0d exp 33", name, done_k);
    end
    n_tests++;
    if (got_q !== eq) begin
      n_fail++;
      $display("FAIL %s quotient got %h exp %h", name, got_q, eq);
    end
    n_tests++;
    if (got_r !== er) begin
      n_fail++;
      $display("FAIL %s remainder got %h exp %h", name, got_r, er);
    end
    last_q = eq;
    last_r = er;
  endtask

  task automatic go_idle();
    div_start = 1'b0;
    flush     = 1'b0;
    #1;
    n_tests++;
    if (div_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_done got %b exp 0", div_done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    flush      = 1'b0;
    src1       = 32'd0;
    src2       = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (dbg_state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got %0d exp 0", dbg_state_o);
    end
    n_tests++;
    if ({div_stall, div_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 00", {div_stall, div_done});
    end
    n_tests++;
    if (quotient !== 32'd0 || remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h/%h exp 0/0", quotient, remainder);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    go_idle();
  endtask

  task automatic test_signed();
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    go_idle();
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    go_idle();
    run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
    go_idle();
  endtask

  task automatic test_corners();
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    go_idle();
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
    go_idle();
    run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB);
    go_idle();
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    go_idle();
  endtask

  task automatic test_flush();
    int done_seen;
    div_start  = 1'b1;
    div_signed = 1'b0;
    src1       = 32'd1000;
    src2       = 32'd3;
    repeat (11) @(negedge clk);   // now in CALC cycle 10
    flush = 1'b1;
    #1;
    n_tests++;
    if ({div_stall, div_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_stall got %b exp 00", {div_stall, div_done});
    end
    @(negedge clk);
    flush     = 1'b0;
    div_start = 1'b0;
    #1;
    n_tests++;
    if (dbg_state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_state got %0d exp 0", dbg_state_o);
    end
    n_tests++;
    if (quotient !== last_q || remainder !== last_r) begin
      n_fail++;
      $display("FAIL flush_hold got %h/%h exp %h/%h", quotient, remainder, last_q, last_r);
    end
    done_seen = 0;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      #1;
      if (div_done) done_seen++;
    end
    n_tests++;
    if (done_seen !== 0) begin
      n_fail++;
      $display("FAIL flush_no_done got %0d exp 0", done_seen);
    end
    // flush together with div_start in IDLE must not start anything
    flush     = 1'b1;
    div_start = 1'b1;
    #1;
    n_tests++;
    if (div_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start_stall got %b exp 0", div_stall);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (dbg_state_o !== 2'd0) begin
      n_fail++;
      $display("FAIL flush_start_state got %0d exp 0", dbg_state_o);
    end
    flush     = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    run_div("divu_9_4", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1);
    go_idle();
  endtask

  task automatic test_back_to_back();
    run_div("b2b_20_3", 1'b0, 32'd20, 32'd3, 32'd6, 32'd2);
    run_div("b2b_20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2);
    go_idle();
  endtask

  task automatic test_reset_mid();
    div_start  = 1'b1;
    div_signed = 1'b0;
    src1       = 32'd200;
    src2       = 32'd9;
    repeat (6) @(negedge clk);    // now in CALC cycle 5
    resetn = 1'b0;
    #1;
    n_tests++;
    if (div_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_done got %b exp 0", div_done);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (dbg_state_o !== 2'd0 || div_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state got %0d/%b exp 0/0", dbg_state_o, div_done);
    end
    n_tests++;
    if (quotient !== 32'd0 || remainder !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got %h/%h exp 0/0", quotient, remainder);
    end
    @(negedge clk);
    resetn = 1'b1;
    // div_start stays high, so the divide restarts right away
    run_div("rst_restart_200_9", 1'b0, 32'd200, 32'd9, 32'd22, 32'd2);
    go_idle();
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_corners();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
